// File: rtl/caliptra_prim_sec_cfg_arb.sv
// Round-robin write arbiter and lock controller for one hardened config register (optional shadow copy: CALIPTRA_PRIM_SEC_CFG_SHADOW_EN).
// Latency: gnt_o one cycle after req_i is sampled in Idle/Locked, cfg_o/locked_o one cycle after the grant; one grant per 2 cycles.
// Backpressure: req_i is a level held until gnt_o pulses; a locked register still grants, but pulses denied_o and drops the write.

module caliptra_prim_sec_anchor_flop #(
    parameter int unsigned      Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);
    logic [Width-1:0] q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q <= ResetValue;
        else         q <= d_i;
    end

    assign q_o = q;
endmodule

module caliptra_prim_sec_cfg_arb #(
    parameter int unsigned      NumReq     = 4,
    parameter int unsigned      Width      = 32,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_i,
    input  logic [NumReq-1:0]       lock_i,
    input  logic [NumReq*Width-1:0] wdata_i,
    output logic [NumReq-1:0]       gnt_o,
    output logic                    denied_o,
    output logic [Width-1:0]        cfg_o,
    output logic                    locked_o,
    output logic                    err_o
);
    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    // Sparse codes, pairwise Hamming distance >= 3.
    typedef enum logic [5:0] {
        StIdle    = 6'b001011,
        StGrant   = 6'b110001,
        StLocked  = 6'b010110,
        StLkGrant = 6'b101100,
        StError   = 6'b111111
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        state_raw;
    logic [IdxW-1:0]   rr_q, win_q, arb_idx, rr_inc;
    logic [NumReq-1:0] gnt_q;
    logic              denied_q, err_q;
    logic [Width-1:0]  cfg_q, cfg_d, win_wdata;
    logic              locked_q, lock_d, lock_set;
    logic              cfg_we, win_lock, any_req, mismatch;

    caliptra_prim_sec_anchor_flop #(.Width(6), .ResetValue(6'(StIdle))) u_state_flop (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (state_d),
        .q_o   (state_raw)
    );
    assign state_q = state_e'(state_raw);

    assign any_req = |req_i;

    // Descending scan so the requester closest at/after rr_q is the last to assign.
    always_comb begin
        logic [IdxW-1:0] idx;
        arb_idx = '0;
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            idx = IdxW'((int'(rr_q) + i) % int'(NumReq));
            if (req_i[idx]) arb_idx = idx;
        end
    end

    always_comb begin
        win_wdata = '0;
        for (int k = 0; k < int'(NumReq); k++) begin
            if (win_q == IdxW'(k)) win_wdata = wdata_i[k*Width +: Width];
        end
    end

    assign win_lock = lock_i[win_q];
    assign rr_inc   = (win_q == IdxW'(NumReq - 1)) ? '0 : win_q + 1'b1;
    assign cfg_we   = (state_q == StGrant);
    assign cfg_d    = cfg_we ? win_wdata : cfg_q;
    assign lock_set = (cfg_we & win_lock) | (state_d == StError);
    assign lock_d   = locked_q | lock_set;

    caliptra_prim_sec_anchor_flop #(.Width(Width), .ResetValue(ResetValue)) u_cfg_flop (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (cfg_d),
        .q_o   (cfg_q)
    );

    caliptra_prim_sec_anchor_flop #(.Width(1), .ResetValue(1'b0)) u_lock_flop (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (lock_d),
        .q_o   (locked_q)
    );

`ifdef CALIPTRA_PRIM_SEC_CFG_SHADOW_EN
    logic [Width-1:0] shadow_q, shadow_d;
    logic             lock_n_q, lock_n_d;

    // Complement copies follow their own update path so a single upset is visible.
    assign shadow_d = cfg_we ? ~win_wdata : shadow_q;
    assign lock_n_d = lock_n_q & ~lock_set;

    caliptra_prim_sec_anchor_flop #(.Width(Width), .ResetValue(~ResetValue)) u_cfg_shadow_flop (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (shadow_d),
        .q_o   (shadow_q)
    );

    caliptra_prim_sec_anchor_flop #(.Width(1), .ResetValue(1'b1)) u_lock_shadow_flop (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (lock_n_d),
        .q_o   (lock_n_q)
    );

    assign mismatch = (cfg_q != ~shadow_q) || (locked_q != ~lock_n_q);
`else
    assign mismatch = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (any_req) state_d = StGrant;
            StGrant:   state_d = win_lock ? StLocked : StIdle;
            StLocked:  if (any_req) state_d = StLkGrant;
            StLkGrant: state_d = StLocked;
            StError:   state_d = StError;
            default:   state_d = StError;
        endcase
        if (mismatch && (state_q != StGrant)) state_d = StError;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            denied_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            gnt_q    <= '0;
            denied_q <= 1'b0;
            err_q    <= err_q | (state_d == StError);
            if ((state_d == StGrant) || (state_d == StLkGrant)) begin
                win_q    <= arb_idx;
                gnt_q    <= NumReq'(1) << arb_idx;
                denied_q <= (state_d == StLkGrant);
            end
            if ((state_q == StGrant) || (state_q == StLkGrant)) rr_q <= rr_inc;
        end
    end

    assign gnt_o    = gnt_q;
    assign denied_o = denied_q;
    assign cfg_o    = cfg_q;
    assign locked_o = locked_q;
    assign err_o    = err_q;
endmodule
